// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types and constants.
package aes_pkg;

  localparam int unsigned NR = 10;

  typedef logic [127:0] rkey_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } ks_state_e;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

endpackage

// File: rtl/aes_sub_word.sv
// Combinational AES SubWord: four forward S-box byte lookups on a 32-bit word.
module aes_sub_word (
  input  logic [31:0] in_i,
  output logic [31:0] out_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_o = {SBOX[in_i[31:24]], SBOX[in_i[23:16]], SBOX[in_i[15:8]], SBOX[in_i[7:0]]};

endmodule

// File: rtl/aes_key_sched_seq.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry store.
// Optional AES_KS_ZEROIZE_EN adds a zeroize input that wipes all key material.
module aes_key_sched_seq #(
  parameter int unsigned NR = 10,
  parameter int unsigned KW = 128
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef AES_KS_ZEROIZE_EN
  input  logic          zeroize,
`endif
  input  logic [KW-1:0] key_in,
  input  logic          key_valid,
  output logic          key_ready,
  output logic [KW-1:0] rk_out,
  output logic          rk_out_valid,
  output logic [3:0]    rk_out_idx,
  output logic          keys_valid,
  input  logic [3:0]    rd_round,
  output logic [KW-1:0] rd_key
);
  import aes_pkg::*;

  if (NR != 10 || KW != 128) begin : g_bad_cfg
    $error("aes_key_sched_seq supports AES-128 only (NR=10, KW=128)");
  end

  ks_state_e   state_q, state_d;
  logic [3:0]  ctr_q, ctr_d;
  logic [KW-1:0] rk_q [NR+1];
  logic [KW-1:0] rk_d [NR+1];
  logic [KW-1:0] rk_out_q, rk_out_d;
  logic [3:0]  idx_q, idx_d;
  logic        out_valid_q, out_valid_d;
  logic        keys_valid_q, keys_valid_d;
  logic        zero_req;

`ifdef AES_KS_ZEROIZE_EN
  assign zero_req = zeroize;
`else
  assign zero_req = 1'b0;
`endif

  // The previous round key is always the one on rk_out, so no store read-back is needed.
  logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7, sub_w;
  logic [7:0]  rcon;
  logic [KW-1:0] next_key;

  assign {w0, w1, w2, w3} = rk_out_q;

  aes_sub_word u_sub_word (
    .in_i  ({w3[23:0], w3[31:24]}),
    .out_o (sub_w)
  );

  always_comb begin
    rcon = '0;
    for (int unsigned i = 1; i <= NR; i++) begin
      if (ctr_q == 4'(i)) rcon = RCON[i];
    end
  end

  assign w4 = w0 ^ sub_w ^ {rcon, 24'h0};
  assign w5 = w1 ^ w4;
  assign w6 = w2 ^ w5;
  assign w7 = w3 ^ w6;
  assign next_key = {w4, w5, w6, w7};

  always_comb begin
    state_d      = state_q;
    ctr_d        = ctr_q;
    rk_d         = rk_q;
    rk_out_d     = rk_out_q;
    idx_d        = idx_q;
    out_valid_d  = 1'b0;
    keys_valid_d = keys_valid_q;
    key_ready    = (state_q != EXPAND);

    unique case (state_q)
      IDLE, DONE: begin
        if (key_valid) begin
          rk_d[0]      = key_in;
          rk_out_d     = key_in;
          idx_d        = '0;
          out_valid_d  = 1'b1;
          ctr_d        = 4'd1;
          keys_valid_d = 1'b0;
          state_d      = EXPAND;
        end
      end
      EXPAND: begin
        for (int unsigned i = 1; i <= NR; i++) begin
          if (ctr_q == 4'(i)) rk_d[i] = next_key;
        end
        rk_out_d    = next_key;
        idx_d       = ctr_q;
        out_valid_d = 1'b1;
        ctr_d       = ctr_q + 4'd1;
        if (ctr_q == 4'(NR)) begin
          state_d      = DONE;
          keys_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Zeroize wins over any accept or expansion step in the same cycle.
    if (zero_req) begin
      state_d      = IDLE;
      ctr_d        = '0;
      rk_out_d     = '0;
      idx_d        = '0;
      out_valid_d  = 1'b0;
      keys_valid_d = 1'b0;
      for (int unsigned i = 0; i <= NR; i++) rk_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ctr_q        <= '0;
      rk_out_q     <= '0;
      idx_q        <= '0;
      out_valid_q  <= 1'b0;
      keys_valid_q <= 1'b0;
      for (int unsigned i = 0; i <= NR; i++) rk_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      ctr_q        <= ctr_d;
      rk_out_q     <= rk_out_d;
      idx_q        <= idx_d;
      out_valid_q  <= out_valid_d;
      keys_valid_q <= keys_valid_d;
      for (int unsigned i = 0; i <= NR; i++) rk_q[i] <= rk_d[i];
    end
  end

  always_comb begin
    rd_key = '0;
    for (int unsigned i = 0; i <= NR; i++) begin
      if (rd_round == 4'(i)) rd_key = rk_q[i];
    end
  end

  assign rk_out       = rk_out_q;
  assign rk_out_valid = out_valid_q;
  assign rk_out_idx   = idx_q;
  assign keys_valid   = keys_valid_q;

endmodule
